// File: rtl/jt10_adpcmb_enc.sv
// ADPCM-B encoder and memory writer: quantises 16-bit PCM to 4-bit ADPCM-B nibbles,
// packs two per byte and writes them between astart and aend.
module jt10_adpcmb_enc #(
  parameter int STEP_MIN = 127,
  parameter int STEP_MAX = 24576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        arepeat,
  input  logic [15:0] astart,
  input  logic [15:0] aend,
  input  logic [15:0] pcm_in,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  output logic [23:0] addr,
  output logic [7:0]  dout,
  output logic        we,
  input  logic        wok,
  output logic        flag,
  input  logic        clr_flag,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_WAIT = 4'd1, ST_DIFF = 4'd2, ST_Q2 = 4'd3, ST_Q1 = 4'd4,
    ST_Q0 = 4'd5, ST_UPD = 4'd6, ST_WR = 4'd7, ST_DONE = 4'd8
  } state_t;

  localparam logic [15:0] STEP_LO = 16'(STEP_MIN);
  localparam logic [15:0] STEP_HI = 16'(STEP_MAX);

  function automatic logic [7:0] step_mul(input logic [2:0] m);
    case (m)
      3'd4:    step_mul = 8'd77;
      3'd5:    step_mul = 8'd102;
      3'd6:    step_mul = 8'd128;
      3'd7:    step_mul = 8'd153;
      default: step_mul = 8'd57;
    endcase
  endfunction

  state_t      state_r, state_nx;
  logic        on_d_r;
  logic [15:0] sample_r, sample_nx;
  logic [15:0] x_r, x_nx;
  logic [15:0] step_r, step_nx;
  logic [16:0] mag_r, mag_nx;
  logic        sign_r, sign_nx, b2_r, b2_nx, b1_r, b1_nx, b0_r, b0_nx;
  logic        phase_r, phase_nx;
  logic [23:0] addr_r, addr_nx;
  logic [7:0]  dout_r, dout_nx;
  logic        we_r, we_nx, flag_r, flag_nx, ready_r, ready_nx, busy_r, busy_nx;
  logic        flag_set_s;

  logic signed [16:0] diff_s;
  logic [16:0] abs_s;
  logic [2:0]  m_s;
  logic [3:0]  nibble_s;
  logic [16:0] delta_s;
  logic [17:0] x_sum_s;
  logic [15:0] x_upd_s;
  logic [15:0] step_raw_s;
  logic [15:0] step_upd_s;
  logic [23:0] last_addr_s;

  assign diff_s      = $signed({sample_r[15], sample_r}) - $signed({x_r[15], x_r});
  assign abs_s       = diff_s[16] ? -diff_s : diff_s;
  assign m_s         = {b2_r, b1_r, b0_r};
  assign nibble_s    = {sign_r, m_s};
  assign delta_s     = 17'(({16'd0, m_s, 1'b1} * {4'd0, step_r}) >> 3);
  assign x_sum_s     = sign_r ? ({{2{x_r[15]}}, x_r} - {1'b0, delta_s})
                              : ({{2{x_r[15]}}, x_r} + {1'b0, delta_s});
  assign step_raw_s  = 16'(({16'd0, step_mul(m_s)} * {8'd0, step_r}) >> 6);
  assign last_addr_s = {aend, 8'hFF};

  // Predictor saturation and step clamping for the UPD cycle
  always_comb begin
    if (!x_sum_s[17] && (x_sum_s[16] || x_sum_s[15])) begin
      x_upd_s = 16'h7FFF;
    end else if (x_sum_s[17] && !(x_sum_s[16] && x_sum_s[15])) begin
      x_upd_s = 16'h8000;
    end else begin
      x_upd_s = x_sum_s[15:0];
    end
    if (step_raw_s < STEP_LO) begin
      step_upd_s = STEP_LO;
    end else if (step_raw_s > STEP_HI) begin
      step_upd_s = STEP_HI;
    end else begin
      step_upd_s = step_raw_s;
    end
  end

  // Next-state and next-output logic; on low / on rising edge override the sequence
  always_comb begin
    state_nx   = state_r;
    sample_nx  = sample_r;
    x_nx       = x_r;
    step_nx    = step_r;
    mag_nx     = mag_r;
    sign_nx    = sign_r;
    b2_nx      = b2_r;
    b1_nx      = b1_r;
    b0_nx      = b0_r;
    phase_nx   = phase_r;
    addr_nx    = addr_r;
    dout_nx    = dout_r;
    flag_set_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (pcm_valid && ready_r) begin
          sample_nx = pcm_in;
          state_nx  = ST_DIFF;
        end else begin
          state_nx  = ST_WAIT;
        end
      end
      ST_DIFF: begin
        sign_nx  = diff_s[16];
        mag_nx   = abs_s;
        state_nx = ST_Q2;
      end
      ST_Q2: begin
        b2_nx = (mag_r >= {1'b0, step_r});
        if (mag_r >= {1'b0, step_r}) begin
          mag_nx = mag_r - {1'b0, step_r};
        end else begin
          mag_nx = mag_r;
        end
        state_nx = ST_Q1;
      end
      ST_Q1: begin
        b1_nx = (mag_r >= {2'b00, step_r[15:1]});
        if (mag_r >= {2'b00, step_r[15:1]}) begin
          mag_nx = mag_r - {2'b00, step_r[15:1]};
        end else begin
          mag_nx = mag_r;
        end
        state_nx = ST_Q0;
      end
      ST_Q0: begin
        b0_nx    = (mag_r >= {3'b000, step_r[15:2]});
        state_nx = ST_UPD;
      end
      ST_UPD: begin
        x_nx     = x_upd_s;
        step_nx  = step_upd_s;
        phase_nx = ~phase_r;
        if (phase_r) begin
          dout_nx  = {nibble_s, dout_r[3:0]};
          state_nx = ST_WAIT;
        end else begin
          dout_nx  = {dout_r[7:4], nibble_s};
          state_nx = ST_WR;
        end
      end
      ST_WR: begin
        if (wok) begin
          if (addr_r == last_addr_s) begin
            flag_set_s = 1'b1;
            if (arepeat) begin
              addr_nx  = {astart, 8'h00};
              state_nx = ST_WAIT;
            end else begin
              state_nx = ST_DONE;
            end
          end else begin
            addr_nx  = addr_r + 24'd1;
            state_nx = ST_WAIT;
          end
        end else begin
          state_nx = ST_WR;
        end
      end
      ST_IDLE: state_nx = ST_IDLE;
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
    if (!on) begin
      state_nx   = ST_IDLE;
      flag_set_s = 1'b0;
    end else if (!on_d_r) begin
      state_nx   = ST_WAIT;
      addr_nx    = {astart, 8'h00};
      x_nx       = 16'h0000;
      step_nx    = STEP_LO;
      phase_nx   = 1'b1;
      flag_set_s = 1'b0;
    end else begin
      state_nx   = state_nx;
    end
    if (flag_set_s) begin
      flag_nx = 1'b1;
    end else if (clr_flag) begin
      flag_nx = 1'b0;
    end else begin
      flag_nx = flag_r;
    end
    ready_nx = (state_nx == ST_WAIT);
    we_nx    = (state_nx == ST_WR);
    busy_nx  = (state_nx != ST_IDLE) && (state_nx != ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      on_d_r   <= 1'b0;
      sample_r <= 16'h0000;
      x_r      <= 16'h0000;
      step_r   <= STEP_LO;
      mag_r    <= 17'd0;
      sign_r   <= 1'b0;
      b2_r     <= 1'b0;
      b1_r     <= 1'b0;
      b0_r     <= 1'b0;
      phase_r  <= 1'b1;
      addr_r   <= 24'd0;
      dout_r   <= 8'd0;
      we_r     <= 1'b0;
      flag_r   <= 1'b0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      on_d_r   <= on;
      sample_r <= sample_nx;
      x_r      <= x_nx;
      step_r   <= step_nx;
      mag_r    <= mag_nx;
      sign_r   <= sign_nx;
      b2_r     <= b2_nx;
      b1_r     <= b1_nx;
      b0_r     <= b0_nx;
      phase_r  <= phase_nx;
      addr_r   <= addr_nx;
      dout_r   <= dout_nx;
      we_r     <= we_nx;
      flag_r   <= flag_nx;
      ready_r  <= ready_nx;
      busy_r   <= busy_nx;
    end
  end

  assign pcm_ready = ready_r;
  assign addr      = addr_r;
  assign dout      = dout_r;
  assign we        = we_r;
  assign flag      = flag_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_jt10_adpcmb_enc.sv
// Self-checking bench for jt10_adpcmb_enc: fixed vectors, random samples against an
// integer reference encoder, and end-of-range / abort / reset sequences.
module tb_jt10_adpcmb_enc;

  logic        clk = 1'b0;
  logic        rst, on, arepeat, pcm_valid, wok, clr_flag;
  logic [15:0] astart, aend, pcm_in;
  logic        pcm_ready, we, flag, busy;
  logic [23:0] addr;
  logic [7:0]  dout;

  always #5 clk = ~clk;

  jt10_adpcmb_enc dut (
    .clk(clk), .rst(rst), .on(on), .arepeat(arepeat), .astart(astart), .aend(aend),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .addr(addr),
    .dout(dout), .we(we), .wok(wok), .flag(flag), .clr_flag(clr_flag), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int mx, mstep;
  int mul_tab[8] = '{57, 57, 57, 57, 77, 102, 128, 153};

  typedef struct {
    bit          restart;
    logic [15:0] st;
    int          s0;
    int          s1;
    logic [7:0]  eb;
    logic [23:0] ea;
  } vec_t;
  vec_t tbl[5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference encoder: plain integer arithmetic on the quantiser rules
  task automatic model_step(input int s, output logic [3:0] nib);
    int d, mag, m, thr, delta;
    d   = s - mx;
    mag = (d < 0) ? -d : d;
    m   = 0;
    for (int k = 2; k >= 0; k--) begin
      thr = mstep >> (2 - k);
      if (mag >= thr) begin
        m   = m + (1 << k);
        mag = mag - thr;
      end
    end
    nib   = 4'(((d < 0) ? 8 : 0) + m);
    delta = ((2 * m + 1) * mstep) / 8;
    mx    = (d < 0) ? mx - delta : mx + delta;
    if (mx > 32767)  mx = 32767;
    if (mx < -32768) mx = -32768;
    mstep = (mstep * mul_tab[m]) / 64;
    if (mstep < 127)   mstep = 127;
    if (mstep > 24576) mstep = 24576;
  endtask

  task automatic model_pair(input int s0, input int s1, output logic [7:0] b);
    logic [3:0] n0, n1;
    model_step(s0, n0);
    model_step(s1, n1);
    b = {n0, n1};
  endtask

  function automatic int rnd_sample();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic restart(input logic [15:0] st, input logic [15:0] en, input logic rep);
    on = 1'b0;
    tick;
    tick;
    astart  = st;
    aend    = en;
    arepeat = rep;
    on      = 1'b1;
    tick;
    mx    = 0;
    mstep = 127;
  endtask

  task automatic send_sample(input int s);
    int n = 0;
    while (!pcm_ready && n < 60) begin
      tick;
      n++;
    end
    if (!pcm_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 60 cycles");
      return;
    end
    pcm_in    = 16'(s);
    pcm_valid = 1'b1;
    tick;
    pcm_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [23:0] ea, input logic [7:0] eb, input int hold,
                              input bit clr_ack);
    int n = 0;
    while (!we && n < 60) begin
      tick;
      n++;
    end
    if (!we) begin
      total++;
      bad++;
      $display("FAIL write_timeout: got we=0 expected we=1 within 60 cycles");
      return;
    end
    chk("wr_addr", 32'(addr), 32'(ea));
    chk("wr_data", 32'(dout), 32'(eb));
    for (int k = 0; k < hold; k++) begin
      tick;
      chk("hold_we", 32'(we), 32'd1);
      chk("hold_addr", 32'(addr), 32'(ea));
      chk("hold_data", 32'(dout), 32'(eb));
      chk("hold_ready", 32'(pcm_ready), 32'd0);
    end
    wok      = 1'b1;
    clr_flag = clr_ack;
    tick;
    wok      = 1'b0;
    clr_flag = 1'b0;
    chk("we_drop", 32'(we), 32'd0);
  endtask

  task automatic dut_pair(input int s0, input int s1, input logic [23:0] ea,
                          input logic [7:0] eb, input int hold, input bit clr_ack);
    send_sample(s0);
    send_sample(s1);
    expect_write(ea, eb, hold, clr_ack);
  endtask

  initial begin
    logic [7:0] mb;
    int s0, s1, n;
    bit saw_we;

    tbl[0] = '{1'b1, 16'h0012, 1000, 1000, 8'h77, 24'h001200};
    tbl[1] = '{1'b1, 16'h0034, -100, 0, 8'hB3, 24'h003400};
    tbl[2] = '{1'b1, 16'h0000, 0, 0, 8'h08, 24'h000000};
    tbl[3] = '{1'b1, 16'hFFFF, 32767, -32768, 8'h7F, 24'hFFFF00};
    tbl[4] = '{1'b0, 16'hFFFF, -330, -330, 8'h08, 24'hFFFF01};

    rst = 1'b1; on = 1'b0; arepeat = 1'b0; pcm_valid = 1'b0; wok = 1'b0; clr_flag = 1'b0;
    astart = 16'h0000; aend = 16'hFFFF; pcm_in = 16'h0000;
    mx = 0; mstep = 127;
    tick; tick; tick;
    chk("rst_ready", 32'(pcm_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_ready", 32'(pcm_ready), 32'd0);

    // Fixed vectors
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].restart) begin
        restart(tbl[i].st, 16'hFFFF, 1'b0);
        chk("start_addr", 32'(addr), 32'({tbl[i].st, 8'h00}));
        chk("start_busy", 32'(busy), 32'd1);
      end
      model_pair(tbl[i].s0, tbl[i].s1, mb);
      dut_pair(tbl[i].s0, tbl[i].s1, tbl[i].ea, tbl[i].eb, 0, 1'b0);
    end

    // Write wait: wok held low for 5 cycles
    restart(16'h0200, 16'hFFFF, 1'b0);
    s0 = rnd_sample(); s1 = rnd_sample();
    model_pair(s0, s1, mb);
    dut_pair(s0, s1, 24'h020000, mb, 5, 1'b0);
    s0 = rnd_sample(); s1 = rnd_sample();
    model_pair(s0, s1, mb);
    dut_pair(s0, s1, 24'h020001, mb, 0, 1'b0);

    // Random stream against the model
    restart(16'h0300, 16'hFFFF, 1'b0);
    for (int i = 0; i < 30; i++) begin
      s0 = rnd_sample(); s1 = rnd_sample();
      model_pair(s0, s1, mb);
      dut_pair(s0, s1, 24'h030000 + 24'(i), mb, i % 3, 1'b0);
    end

    // Saturation: alternating full-scale samples
    restart(16'h0400, 16'hFFFF, 1'b0);
    for (int i = 0; i < 32; i++) begin
      model_pair(32767, -32768, mb);
      dut_pair(32767, -32768, 24'h040000 + 24'(i), mb, 0, 1'b0);
    end

    // End of range without repeat; clr_flag on the final ack loses to the set
    restart(16'h0001, 16'h0001, 1'b0);
    for (int i = 0; i < 256; i++) begin
      s0 = rnd_sample(); s1 = rnd_sample();
      model_pair(s0, s1, mb);
      dut_pair(s0, s1, 24'h000100 + 24'(i), mb, 0, (i == 255));
      if (i == 254) chk("flag_early", 32'(flag), 32'd0);
    end
    chk("eor_flag", 32'(flag), 32'd1);
    chk("eor_busy", 32'(busy), 32'd0);
    pcm_valid = 1'b1;
    saw_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (pcm_ready || we) saw_we = 1'b1;
    end
    pcm_valid = 1'b0;
    chk("done_no_accept", 32'(saw_we), 32'd0);
    clr_flag = 1'b1;
    tick;
    clr_flag = 1'b0;
    chk("flag_clear", 32'(flag), 32'd0);

    // End of range with repeat: wraps to astart, predictor continues
    restart(16'h0001, 16'h0001, 1'b1);
    for (int i = 0; i < 256; i++) begin
      s0 = rnd_sample(); s1 = rnd_sample();
      model_pair(s0, s1, mb);
      dut_pair(s0, s1, 24'h000100 + 24'(i), mb, 0, 1'b0);
    end
    chk("rep_flag", 32'(flag), 32'd1);
    chk("rep_busy", 32'(busy), 32'd1);
    s0 = rnd_sample(); s1 = rnd_sample();
    model_pair(s0, s1, mb);
    dut_pair(s0, s1, 24'h000100, mb, 0, 1'b0);

    // Abort after an odd sample count
    restart(16'h0500, 16'hFFFF, 1'b0);
    send_sample(rnd_sample());
    n = 0;
    while (!pcm_ready && n < 60) begin
      tick;
      n++;
    end
    chk("abort_ready_back", 32'(pcm_ready), 32'd1);
    on = 1'b0;
    tick;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(pcm_ready), 32'd0);
    chk("abort_flag_kept", 32'(flag), 32'd1);
    saw_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (we) saw_we = 1'b1;
    end
    chk("abort_no_write", 32'(saw_we), 32'd0);
    restart(16'h0500, 16'hFFFF, 1'b0);
    s0 = rnd_sample(); s1 = rnd_sample();
    model_pair(s0, s1, mb);
    dut_pair(s0, s1, 24'h050000, mb, 0, 1'b0);

    // Reset in the middle of a pending write
    restart(16'h0600, 16'hFFFF, 1'b0);
    send_sample(1234);
    send_sample(-4321);
    n = 0;
    while (!we && n < 60) begin
      tick;
      n++;
    end
    chk("mid_wr_we", 32'(we), 32'd1);
    rst = 1'b1;
    on  = 1'b0;
    tick;
    rst = 1'b0;
    chk("rst_wr_we", 32'(we), 32'd0);
    chk("rst_wr_busy", 32'(busy), 32'd0);
    chk("rst_wr_addr", 32'(addr), 32'd0);
    chk("rst_wr_dout", 32'(dout), 32'd0);
    chk("rst_wr_flag", 32'(flag), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
